// File: rtl/z80_bus_timing_pkg.sv
// z80_bus_timing_pkg: shared codes and types for the Z80 machine-cycle bus sequencer.
package z80_bus_timing_pkg;

    // Bus cycle type codes as presented on cyc_type; codes 5..7 are all internal cycles
    localparam logic [2:0] CYC_FETCH  = 3'd0;
    localparam logic [2:0] CYC_MEM_RD = 3'd1;
    localparam logic [2:0] CYC_MEM_WR = 3'd2;
    localparam logic [2:0] CYC_IO_RD  = 3'd3;
    localparam logic [2:0] CYC_IO_WR  = 3'd4;
    localparam logic [2:0] CYC_INT    = 3'd5;

    // One value per T-state of the machine cycle, plus idle and bus-granted
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_TA,
        ST_T3,
        ST_T4,
        ST_BUSAK
    } tstate_t;

    // Active-low control strobes driven to the pin layer
    typedef struct packed {
        logic m1_n;
        logic mreq_n;
        logic iorq_n;
        logic rd_n;
        logic wr_n;
        logic rfsh_n;
    } strobes_t;

    localparam strobes_t STROBES_IDLE = '{default: 1'b1};

    function automatic logic is_io(input logic [2:0] cyc_type);
        return (cyc_type == CYC_IO_RD) || (cyc_type == CYC_IO_WR);
    endfunction

    function automatic logic is_read(input logic [2:0] cyc_type);
        return (cyc_type == CYC_MEM_RD) || (cyc_type == CYC_IO_RD);
    endfunction

endpackage

// File: rtl/z80_bus_timing.sv
// z80_bus_timing: T-state accurate bus cycle sequencer (fetch, memory, I/O, internal)
// with WAIT_n stretching, I/O auto-wait states and BUSRQ_n/BUSACK hand-over.
// Every pin-facing output is registered; the strobe table is evaluated for the
// state being entered so each value holds for the whole T-state.
module z80_bus_timing
    import z80_bus_timing_pkg::*;
#(
    parameter int IO_AUTO_WAIT = 1,
    parameter int FETCH_RFSH   = 1
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        cyc_req,
    input  logic [2:0]  cyc_type,
    input  logic [15:0] cyc_addr,
    input  logic [7:0]  cyc_wdata,
    input  logic [15:0] rfsh_addr,
    output logic        cyc_ready,
    output logic        cyc_done,
    output logic [7:0]  cyc_rdata,
    output logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    output logic        M1_n,
    output logic        MREQ_n,
    output logic        IORQ_n,
    output logic        RD_n,
    output logic        WR_n,
    output logic        RFSH_n,
    input  logic        WAIT_n,
    input  logic        BUSRQ_n,
    output logic        BUSACK
);

    localparam bit         HAS_AUTO_WAIT = (IO_AUTO_WAIT > 0);
    localparam logic [1:0] TA_INIT       = (IO_AUTO_WAIT > 0) ? 2'(IO_AUTO_WAIT - 1) : 2'd0;

    tstate_t     state;
    tstate_t     state_nx;
    logic [2:0]  cur_type;
    logic [2:0]  type_nx;
    logic [15:0] cur_addr;
    logic [15:0] addr_nx;
    logic [7:0]  cur_wdata;
    logic [7:0]  wdata_nx;
    logic [1:0]  ta_cnt;
    logic [1:0]  ta_nx;
    logic        capture;
    logic        last_t;

    strobes_t    strobes_q;
    strobes_t    strobes_nx;
    logic [15:0] a_nx;
    logic [7:0]  dout_nx;
    logic        doe_nx;
    logic        busack_nx;
    logic        done_nx;

    // A fetch ends in T4; every other cycle type ends in T3
    assign last_t    = (state == ST_T4) || ((state == ST_T3) && (cur_type != CYC_FETCH));
    assign cyc_ready = ((state == ST_IDLE) || last_t) && BUSRQ_n && RESET_n;

    assign M1_n   = strobes_q.m1_n;
    assign MREQ_n = strobes_q.mreq_n;
    assign IORQ_n = strobes_q.iorq_n;
    assign RD_n   = strobes_q.rd_n;
    assign WR_n   = strobes_q.wr_n;
    assign RFSH_n = strobes_q.rfsh_n;

    // Next T-state, request latching and read-data capture decision
    always_comb begin
        state_nx = state;
        type_nx  = cur_type;
        addr_nx  = cur_addr;
        wdata_nx = cur_wdata;
        ta_nx    = ta_cnt;
        capture  = 1'b0;
        if ((state == ST_IDLE) || last_t) begin
            if ((state == ST_T3) && is_read(cur_type)) begin
                capture = 1'b1;
            end
            if (!BUSRQ_n) begin
                state_nx = ST_BUSAK;
            end else if (cyc_req) begin
                state_nx = ST_T1;
                type_nx  = cyc_type;
                addr_nx  = cyc_addr;
                wdata_nx = cyc_wdata;
            end else begin
                state_nx = ST_IDLE;
            end
        end else begin
            case (state)
                ST_T1: state_nx = ST_T2;
                ST_T2: begin
                    if (is_io(cur_type) && HAS_AUTO_WAIT) begin
                        state_nx = ST_TA;
                        ta_nx    = TA_INIT;
                    end else if (!WAIT_n) begin
                        state_nx = ST_TW;
                    end else begin
                        state_nx = ST_T3;
                        capture  = (cur_type == CYC_FETCH);
                    end
                end
                ST_TA: begin
                    if (ta_cnt != 2'd0) begin
                        ta_nx = ta_cnt - 2'd1;
                    end else if (!WAIT_n) begin
                        state_nx = ST_TW;
                    end else begin
                        state_nx = ST_T3;
                    end
                end
                ST_TW: begin
                    if (WAIT_n) begin
                        state_nx = ST_T3;
                        capture  = (cur_type == CYC_FETCH);
                    end
                end
                ST_T3:    state_nx = ST_T4;
                ST_BUSAK: begin
                    if (BUSRQ_n) begin
                        state_nx = ST_IDLE;
                    end
                end
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // Strobe/address/data table for the T-state being entered
    always_comb begin
        strobes_nx = STROBES_IDLE;
        a_nx       = A;
        dout_nx    = D_out;
        doe_nx     = 1'b0;
        busack_nx  = (state_nx == ST_BUSAK);
        done_nx    = (state_nx == ST_T4) || ((state_nx == ST_T3) && (type_nx != CYC_FETCH));
        if ((state_nx != ST_IDLE) && (state_nx != ST_BUSAK)) begin
            a_nx = addr_nx;
            case (type_nx)
                CYC_FETCH: begin
                    if ((state_nx == ST_T3) || (state_nx == ST_T4)) begin
                        if (FETCH_RFSH != 0) begin
                            a_nx              = rfsh_addr;
                            strobes_nx.rfsh_n = 1'b0;
                            strobes_nx.mreq_n = (state_nx == ST_T4);
                        end
                    end else begin
                        strobes_nx.m1_n   = 1'b0;
                        strobes_nx.mreq_n = 1'b0;
                        strobes_nx.rd_n   = 1'b0;
                    end
                end
                CYC_MEM_RD: begin
                    strobes_nx.mreq_n = 1'b0;
                    strobes_nx.rd_n   = 1'b0;
                end
                CYC_MEM_WR: begin
                    strobes_nx.mreq_n = 1'b0;
                    strobes_nx.wr_n   = (state_nx == ST_T1);
                    doe_nx            = 1'b1;
                    dout_nx           = wdata_nx;
                end
                CYC_IO_RD: begin
                    if (state_nx != ST_T1) begin
                        strobes_nx.iorq_n = 1'b0;
                        strobes_nx.rd_n   = 1'b0;
                    end
                end
                CYC_IO_WR: begin
                    doe_nx  = 1'b1;
                    dout_nx = wdata_nx;
                    if (state_nx != ST_T1) begin
                        strobes_nx.iorq_n = 1'b0;
                        strobes_nx.wr_n   = 1'b0;
                    end
                end
                default: begin
                    strobes_nx = STROBES_IDLE;
                end
            endcase
        end
    end

    // State and output registers; reset aborts any cycle in progress immediately
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= ST_IDLE;
            cur_type  <= CYC_FETCH;
            cur_addr  <= '0;
            cur_wdata <= '0;
            ta_cnt    <= '0;
            strobes_q <= STROBES_IDLE;
            A         <= '0;
            D_out     <= '0;
            D_oe      <= 1'b0;
            BUSACK    <= 1'b0;
            cyc_done  <= 1'b0;
            cyc_rdata <= '0;
        end else begin
            state     <= state_nx;
            cur_type  <= type_nx;
            cur_addr  <= addr_nx;
            cur_wdata <= wdata_nx;
            ta_cnt    <= ta_nx;
            strobes_q <= strobes_nx;
            A         <= a_nx;
            D_out     <= dout_nx;
            D_oe      <= doe_nx;
            BUSACK    <= busack_nx;
            cyc_done  <= done_nx;
            if (capture) begin
                cyc_rdata <= D_in;
            end
        end
    end

endmodule

// File: tb/tb_z80_bus_timing.sv
// tb_z80_bus_timing: builds an expected per-T-state trace from the bus cycle rules
// (one table entry per clock), drives it with randomized inputs and compares outputs.
module tb_z80_bus_timing;

    localparam int IO_WAITS = 1;

    // Cycle type codes
    localparam logic [2:0] T_FETCH  = 3'd0;
    localparam logic [2:0] T_MEM_RD = 3'd1;
    localparam logic [2:0] T_MEM_WR = 3'd2;
    localparam logic [2:0] T_IO_RD  = 3'd3;
    localparam logic [2:0] T_IO_WR  = 3'd4;

    // T-state tags used only to describe the expected sequence
    localparam int S_T1 = 1;
    localparam int S_T2 = 2;
    localparam int S_TA = 3;
    localparam int S_TW = 4;
    localparam int S_T3 = 5;
    localparam int S_T4 = 6;

    logic        CLK = 1'b0;
    logic        RESET_n = 1'b0;
    logic        cyc_req = 1'b0;
    logic [2:0]  cyc_type = '0;
    logic [15:0] cyc_addr = '0;
    logic [7:0]  cyc_wdata = '0;
    logic [15:0] rfsh_addr = '0;
    logic        cyc_ready;
    logic        cyc_done;
    logic [7:0]  cyc_rdata;
    logic [15:0] A;
    logic [7:0]  D_in = '0;
    logic [7:0]  D_out;
    logic        D_oe;
    logic        M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n;
    logic        WAIT_n = 1'b1;
    logic        BUSRQ_n = 1'b1;
    logic        BUSACK;

    z80_bus_timing #(.IO_AUTO_WAIT(IO_WAITS), .FETCH_RFSH(1)) dut (
        .CLK(CLK), .RESET_n(RESET_n),
        .cyc_req(cyc_req), .cyc_type(cyc_type), .cyc_addr(cyc_addr),
        .cyc_wdata(cyc_wdata), .rfsh_addr(rfsh_addr),
        .cyc_ready(cyc_ready), .cyc_done(cyc_done), .cyc_rdata(cyc_rdata),
        .A(A), .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
        .M1_n(M1_n), .MREQ_n(MREQ_n), .IORQ_n(IORQ_n), .RD_n(RD_n), .WR_n(WR_n),
        .RFSH_n(RFSH_n), .WAIT_n(WAIT_n), .BUSRQ_n(BUSRQ_n), .BUSACK(BUSACK)
    );

    always #5 CLK = ~CLK;

    // One clock of stimulus plus the outputs expected during that clock
    typedef struct {
        logic        req;
        logic [2:0]  typ;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [15:0] rfsh;
        logic [7:0]  din;
        logic        wait_n;
        logic        busrq_n;
        logic [5:0]  strobes;
        logic [15:0] a;
        logic [7:0]  dout;
        logic        doe;
        logic        busack;
        logic        done;
        logic        boundary;
        logic        ready;
        logic [7:0]  rdata;
    } slot_t;

    slot_t       sched[$];
    logic [15:0] aExp = '0;
    logic [7:0]  doutExp = '0;
    logic [7:0]  rdataExp = '0;
    int          checks = 0;
    int          failures = 0;
    int          curSlot = 0;

    // Count one comparison and report it when it disagrees
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s slot=%0d got=0x%0h expected=0x%0h", tag, curSlot, observed, expected);
        end
    endtask

    // Strobes {M1,MREQ,IORQ,RD,WR,RFSH} for a T-state of a given cycle type
    function automatic logic [5:0] expStrobes(input int st, input logic [2:0] typ);
        logic m1, mreq, iorq, rd, wr, rf;
        m1 = 1'b1; mreq = 1'b1; iorq = 1'b1; rd = 1'b1; wr = 1'b1; rf = 1'b1;
        case (typ)
            T_FETCH: begin
                if (st == S_T3 || st == S_T4) begin
                    rf   = 1'b0;
                    mreq = (st == S_T4);
                end else begin
                    m1 = 1'b0; mreq = 1'b0; rd = 1'b0;
                end
            end
            T_MEM_RD: begin mreq = 1'b0; rd = 1'b0; end
            T_MEM_WR: begin mreq = 1'b0; wr = (st == S_T1); end
            T_IO_RD:  if (st != S_T1) begin iorq = 1'b0; rd = 1'b0; end
            T_IO_WR:  if (st != S_T1) begin iorq = 1'b0; wr = 1'b0; end
            default:  ;
        endcase
        return {m1, mreq, iorq, rd, wr, rf};
    endfunction

    // A clock with random don't-care inputs and bus-idle expectations
    function automatic slot_t junkSlot();
        slot_t s;
        s.req      = 1'($urandom_range(0, 1));
        s.typ      = 3'($urandom_range(0, 7));
        s.addr     = 16'($urandom);
        s.wdata    = 8'($urandom);
        s.rfsh     = 16'($urandom);
        s.din      = 8'($urandom);
        s.wait_n   = 1'($urandom_range(0, 1));
        s.busrq_n  = 1'($urandom_range(0, 1));
        s.strobes  = 6'h3F;
        s.a        = aExp;
        s.dout     = doutExp;
        s.doe      = 1'b0;
        s.busack   = 1'b0;
        s.done     = 1'b0;
        s.boundary = 1'b0;
        s.ready    = 1'b0;
        s.rdata    = rdataExp;
        return s;
    endfunction

    task automatic addIdle();
        slot_t s;
        s = junkSlot();
        s.req      = 1'b0;
        s.busrq_n  = 1'b1;
        s.boundary = 1'b1;
        sched.push_back(s);
    endtask

    // Present a request in the latest clock (idle or last T-state)
    task automatic presentReq(input logic [2:0] typ, input logic [15:0] addr, input logic [7:0] wdata);
        int idx;
        idx = sched.size() - 1;
        sched[idx].req     = 1'b1;
        sched[idx].typ     = typ;
        sched[idx].addr    = addr;
        sched[idx].wdata   = wdata;
        sched[idx].busrq_n = 1'b1;
    endtask

    // Append one machine cycle: optional idle gap, then T1,T2,[TA..],[TW..],T3,[T4]
    task automatic addCycle(input logic [2:0] typ, input logic [15:0] addr, input logic [7:0] wdata,
                            input logic [15:0] rfsh, input int waits, input int gap, input logic [7:0] dbyte);
        int    seq[$];
        int    nxt;
        slot_t s;
        logic  isWrite, isRead, capt;
        isWrite = (typ == T_MEM_WR) || (typ == T_IO_WR);
        isRead  = (typ == T_MEM_RD) || (typ == T_IO_RD);
        repeat (gap) addIdle();
        presentReq(typ, addr, wdata);
        seq.push_back(S_T1);
        seq.push_back(S_T2);
        if (typ == T_IO_RD || typ == T_IO_WR) repeat (IO_WAITS) seq.push_back(S_TA);
        repeat (waits) seq.push_back(S_TW);
        seq.push_back(S_T3);
        if (typ == T_FETCH) seq.push_back(S_T4);
        for (int i = 0; i < seq.size(); i++) begin
            nxt = (i + 1 < seq.size()) ? seq[i + 1] : 0;
            s = junkSlot();
            s.rfsh = rfsh;
            if (nxt == S_TW) s.wait_n = 1'b0;
            else if (nxt == S_T3) s.wait_n = 1'b1;
            aExp = (typ == T_FETCH && (seq[i] == S_T3 || seq[i] == S_T4)) ? rfsh : addr;
            if (isWrite) doutExp = wdata;
            s.a       = aExp;
            s.dout    = doutExp;
            s.doe     = isWrite;
            s.strobes = expStrobes(seq[i], typ);
            s.rdata   = rdataExp;
            capt = (typ == T_FETCH && nxt == S_T3) || (isRead && seq[i] == S_T3);
            if (capt) s.din = dbyte;
            if (i == seq.size() - 1) begin
                s.done     = 1'b1;
                s.boundary = 1'b1;
                s.req      = 1'b0;
                s.busrq_n  = 1'b1;
            end
            sched.push_back(s);
            if (capt) rdataExp = dbyte;
        end
    endtask

    // Bus request at the latest boundary clock, held for h clocks of BUSAK, then released
    task automatic addBusReq(input int h, input logic pend, input logic [2:0] ptyp,
                             input logic [15:0] paddr, input logic [7:0] pwdata);
        int    idx;
        slot_t s;
        idx = sched.size() - 1;
        sched[idx].busrq_n = 1'b0;
        sched[idx].req     = 1'b1;
        if (pend) begin
            sched[idx].typ   = ptyp;
            sched[idx].addr  = paddr;
            sched[idx].wdata = pwdata;
        end
        for (int k = 0; k < h; k++) begin
            s = junkSlot();
            s.busack  = 1'b1;
            s.busrq_n = (k == h - 1);
            if (pend) begin
                s.req = 1'b1; s.typ = ptyp; s.addr = paddr; s.wdata = pwdata;
            end
            sched.push_back(s);
        end
        addIdle();
    endtask

    // cyc_ready is high only in idle/last T-states while no bus request is pending
    task automatic finalizeSched();
        foreach (sched[i]) sched[i].ready = sched[i].boundary & sched[i].busrq_n;
    endtask

    task automatic resetModel();
        sched.delete();
        aExp = '0;
        doutExp = '0;
        rdataExp = '0;
    endtask

    // Drive up to n scheduled clocks and check the outputs of each
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n && i < sched.size(); i++) begin
            curSlot = i;
            @(posedge CLK);
            #1;
            cyc_req   = sched[i].req;
            cyc_type  = sched[i].typ;
            cyc_addr  = sched[i].addr;
            cyc_wdata = sched[i].wdata;
            rfsh_addr = sched[i].rfsh;
            D_in      = sched[i].din;
            WAIT_n    = sched[i].wait_n;
            BUSRQ_n   = sched[i].busrq_n;
            @(negedge CLK);
            checkOutput("strobes", {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n}, sched[i].strobes);
            checkOutput("A", A, sched[i].a);
            checkOutput("D_oe", D_oe, sched[i].doe);
            checkOutput("D_out", D_out, sched[i].dout);
            checkOutput("BUSACK", BUSACK, sched[i].busack);
            checkOutput("cyc_done", cyc_done, sched[i].done);
            checkOutput("cyc_ready", cyc_ready, sched[i].ready);
            checkOutput("cyc_rdata", cyc_rdata, sched[i].rdata);
        end
    endtask

    initial begin
        logic [2:0] typ;
        int         gap;
        $display("[TB] z80_bus_timing bench start");
        repeat (3) @(negedge CLK);
        RESET_n = 1'b1;

        // Reset in the middle of a fetch (T2)
        resetModel();
        addIdle();
        addCycle(T_FETCH, 16'h4321, 8'h00, 16'h0102, 0, 0, 8'h77);
        finalizeSched();
        applyStimulus(3);
        #2;
        RESET_n = 1'b0;
        cyc_req = 1'b0;
        BUSRQ_n = 1'b1;
        #1;
        checkOutput("rst_strobes", {M1_n, MREQ_n, IORQ_n, RD_n, WR_n, RFSH_n}, 6'h3F);
        checkOutput("rst_A", A, 16'h0000);
        checkOutput("rst_D_oe", D_oe, 1'b0);
        checkOutput("rst_BUSACK", BUSACK, 1'b0);
        checkOutput("rst_ready", cyc_ready, 1'b0);
        repeat (2) begin
            @(posedge CLK);
            #1;
            checkOutput("rst_done", cyc_done, 1'b0);
            checkOutput("rst_rdata", cyc_rdata, 8'h00);
        end
        @(negedge CLK);
        RESET_n = 1'b1;

        // Directed cycles followed by randomized traffic
        resetModel();
        addIdle();
        addCycle(T_FETCH, 16'h1234, 8'h00, 16'h3F05, 0, 1, 8'hC3);
        addCycle(T_MEM_WR, 16'h8000, 8'h5A, 16'($urandom), 2, 1, 8'($urandom));
        addCycle(T_IO_RD, 16'h00FE, 8'h00, 16'($urandom), 0, 1, 8'hA7);
        addCycle(T_FETCH, 16'h0100, 8'h00, 16'h0203, 0, 1, 8'h3E);
        addCycle(T_MEM_RD, 16'h0101, 8'h00, 16'($urandom), 0, 0, 8'h42);
        addCycle(T_MEM_RD, 16'h2000, 8'h00, 16'($urandom), 0, 1, 8'h99);
        addBusReq(2, 1'b1, T_IO_WR, 16'h0010, 8'hE1);
        addCycle(T_IO_WR, 16'h0010, 8'hE1, 16'($urandom), 1, 0, 8'($urandom));
        repeat (60) begin
            typ = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 5) == 0) begin
                addBusReq($urandom_range(1, 3), 1'($urandom_range(0, 1)), typ, 16'($urandom), 8'($urandom));
                gap = 0;
            end else begin
                gap = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 2);
            end
            addCycle(typ, 16'($urandom), 8'($urandom), 16'($urandom), $urandom_range(0, 2), gap, 8'($urandom));
        end
        addIdle();
        addIdle();
        finalizeSched();
        applyStimulus(sched.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
